stopwatch_ctrl: RTL and testbench

//  Front-end controller for the stopwatch counter: turns two raw push-buttons into
//  the counter's single-cycle start_stop/clr commands and a lap-hold level.
//  One-button operation: short press = start/pause; long press = clear (stop+clear if running).

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/stopwatch_ctrl_if.sv | 36 +++
 rtl/stopwatch_ctrl_button_debounce.sv | 79 +++++++
 rtl/stopwatch_ctrl.sv | 126 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and tick constants for the stopwatch front-end
//                controller and the stopwatch counter.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        WAIT_REL = 2'd2
    } run_state_t;

    // Simulation-friendly defaults and their on-board equivalents (100 MHz clock)
    localparam int unsigned c_sim_sync_stages         = 2;
    localparam int unsigned c_sim_debounce_cycles     = 4;
    localparam int unsigned c_sim_long_press_cycles   = 20;
    localparam int unsigned c_sim_tick_count          = 10;
    localparam int unsigned c_board_debounce_cycles   = 500_000;
    localparam int unsigned c_board_long_press_cycles = 100_000_000;
    localparam int unsigned c_board_tick_count        = 1_000_000;

    // Width of a counter that must hold values 0..max_val inclusive
    function automatic int cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl_if
//  Description : Button inputs and counter command outputs of the stopwatch
//                controller; slave is the controller, master the board side.
//  Revision    : 1.0  initial release
// ============================================================================
interface stopwatch_ctrl_if;

    logic btn_run;
    logic btn_lap;
    logic start_stop;
    logic clr;
    logic running;
    logic lap_hold;

    modport master (
        output btn_run,
        output btn_lap,
        input  start_stop,
        input  clr,
        input  running,
        input  lap_hold
    );

    modport slave (
        input  btn_run,
        input  btn_lap,
        output start_stop,
        output clr,
        output running,
        output lap_hold
    );

endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Synchroniser plus counting debouncer for one raw push-button,
//                with single-cycle rise/fall strobes of the debounced level.
//  Revision    : 1.0  initial release
// ============================================================================
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int c_cnt_w    = cnt_width(SYNC_STAGES + DEBOUNCE_CYCLES);
    localparam int c_arm_last = SYNC_STAGES + DEBOUNCE_CYCLES - 1;
    localparam int c_deb_last = DEBOUNCE_CYCLES - 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_armed;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Until armed, the input must be seen low for a full sync+debounce window:
    // a button held through reset is not reported as a new press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!r_armed) begin
                if (w_synced) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_w'(c_arm_last)) begin
                    r_armed <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_synced != r_level) begin
                if (r_cnt == c_cnt_w'(c_deb_last)) begin
                    r_level <= w_synced;
                    r_rise  <= w_synced;
                    r_fall  <= ~w_synced;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Turns the run and lap buttons into start_stop/clr pulses and
//                a lap-hold level for the stopwatch counter.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES       = c_sim_sync_stages,
    parameter int DEBOUNCE_CYCLES   = c_sim_debounce_cycles,
    parameter int LONG_PRESS_CYCLES = c_sim_long_press_cycles
) (
    input  logic             clk,
    input  logic             reset_n,
    stopwatch_ctrl_if.slave  bus
);

    localparam int                c_hold_w   = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_PRESS_CYCLES);

    logic w_run_level;
    logic w_run_rise;
    logic w_run_fall;
    logic w_lap_level;
    logic w_lap_rise;
    logic w_lap_fall;
    logic w_lap_unused;

    run_state_t          r_state;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_start_stop;
    logic                r_clr;
    logic                r_running;
    logic                r_lap_hold;

    button_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (bus.btn_run),
        .level   (w_run_level),
        .rise    (w_run_rise),
        .fall    (w_run_fall)
    );

    button_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lap_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (bus.btn_lap),
        .level   (w_lap_level),
        .rise    (w_lap_rise),
        .fall    (w_lap_fall)
    );

    // Lap button only acts on its rising strobe
    assign w_lap_unused = w_lap_level | w_lap_fall;

    // Lap update uses the pre-update running value; a clr later in this
    // block overrides the lap_hold assignment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_hold_cnt   <= '0;
            r_start_stop <= 1'b0;
            r_clr        <= 1'b0;
            r_running    <= 1'b0;
            r_lap_hold   <= 1'b0;
        end else begin
            r_start_stop <= 1'b0;
            r_clr        <= 1'b0;

            if (w_lap_rise) begin
                r_lap_hold <= r_running ? ~r_lap_hold : 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_run_rise) begin
                        r_state    <= PRESSED;
                        r_hold_cnt <= c_hold_w'(1);
                    end
                end
                PRESSED: begin
                    // Reaching the threshold wins over a release in the same cycle
                    if (r_hold_cnt == c_hold_max) begin
                        r_clr        <= 1'b1;
                        r_start_stop <= r_running;
                        r_running    <= 1'b0;
                        r_lap_hold   <= 1'b0;
                        r_hold_cnt   <= '0;
                        r_state      <= WAIT_REL;
                    end else if (w_run_fall) begin
                        r_start_stop <= 1'b1;
                        r_running    <= ~r_running;
                        r_hold_cnt   <= '0;
                        r_state      <= IDLE;
                    end else if (w_run_level) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (w_run_fall) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_stop = r_start_stop;
    assign bus.clr        = r_clr;
    assign bus.running    = r_running;
    assign bus.lap_hold   = r_lap_hold;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Scoreboard bench for stopwatch_ctrl with directed button
//                sequences and hand-computed output events.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    typedef struct {
        int   cyc;
        logic ss;
        logic clr;
        logic run;
        logic lap;
    } ev_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;
    ev_t  exp_q[$];
    logic prev_run = 1'b0;
    logic prev_lap = 1'b0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic ss, input logic clr, input logic run, input logic lap);
        ev_t e;
        e.cyc = c;
        e.ss  = ss;
        e.clr = clr;
        e.run = run;
        e.lap = lap;
        exp_q.push_back(e);
    endtask

    // Short run press of 8 cycles; pulse lands 7 cycles after the raw release
    task automatic short_run(input logic run_after, input logic lap_after, input logic with_lap);
        bus.btn_run = 1'b1;
        idle(8);
        bus.btn_run = 1'b0;
        if (with_lap) bus.btn_lap = 1'b1;
        push(cyc + 7, 1'b1, 1'b0, run_after, lap_after);
        idle(8);
        bus.btn_lap = 1'b0;
        idle(20);
    endtask

    task automatic lap_press(input logic expect_ev, input logic run_now, input logic lap_after);
        bus.btn_lap = 1'b1;
        if (expect_ev) push(cyc + 7, 1'b0, 1'b0, run_now, lap_after);
        idle(8);
        bus.btn_lap = 1'b0;
        idle(20);
    endtask

    task automatic long_run(input logic ss_exp);
        bus.btn_run = 1'b1;
        push(cyc + 27, ss_exp, 1'b1, 1'b0, 1'b0);
        idle(40);
        bus.btn_run = 1'b0;
        idle(20);
    endtask

    // Monitor: any pulse or level change is an output event to score
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_run = bus.running;
            prev_lap = bus.lap_hold;
        end else if (bus.start_stop || bus.clr || bus.running != prev_run || bus.lap_hold != prev_lap) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got ss=%0b clr=%0b run=%0b lap=%0b expected no event (cycle %0d)",
                         bus.start_stop, bus.clr, bus.running, bus.lap_hold, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_ss_clr_run_lap", int'({bus.start_stop, bus.clr, bus.running, bus.lap_hold}),
                      int'({e.ss, e.clr, e.run, e.lap}));
            end
            prev_run = bus.running;
            prev_lap = bus.lap_hold;
        end
    end

    initial begin
        bus.btn_run = 1'b0;
        bus.btn_lap = 1'b0;
        #1 reset_n = 1'b0;
        idle(3);
        check("reset_start_stop", int'(bus.start_stop), 0);
        check("reset_clr", int'(bus.clr), 0);
        check("reset_running", int'(bus.running), 0);
        check("reset_lap_hold", int'(bus.lap_hold), 0);
        reset_n = 1'b1;
        idle(20);

        // Long press while stopped: clr only, nothing on release
        long_run(1'b0);
        check("stopped_long_running", int'(bus.running), 0);

        // Clean short press starts the counter
        short_run(1'b1, 1'b0, 1'b0);
        check("start_running", int'(bus.running), 1);

        // Bounce shorter than the debounce window is ignored
        for (int i = 0; i < 10; i++) begin
            bus.btn_run = ~bus.btn_run;
            idle(2);
        end
        bus.btn_run = 1'b0;
        idle(30);
        check("bounce_running", int'(bus.running), 1);

        // Lap toggles while running, long press stops and clears together
        lap_press(1'b1, 1'b1, 1'b1);
        lap_press(1'b1, 1'b1, 1'b0);
        lap_press(1'b1, 1'b1, 1'b1);
        long_run(1'b1);
        check("long_running_lap", int'(bus.lap_hold), 0);

        // Lap while stopped, and lap coincident with start/pause
        lap_press(1'b0, 1'b0, 1'b0);
        check("stopped_lap_hold", int'(bus.lap_hold), 0);
        short_run(1'b1, 1'b0, 1'b1);
        short_run(1'b0, 1'b1, 1'b1);
        lap_press(1'b1, 1'b0, 1'b0);

        // Reset in the middle of a press with the button held through it
        short_run(1'b1, 1'b0, 1'b0);
        lap_press(1'b1, 1'b1, 1'b1);
        bus.btn_run = 1'b1;
        idle(16);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_running", int'(bus.running), 0);
        check("async_reset_lap_hold", int'(bus.lap_hold), 0);
        check("async_reset_start_stop", int'(bus.start_stop), 0);
        check("async_reset_clr", int'(bus.clr), 0);
        idle(3);
        reset_n = 1'b1;
        idle(12);
        bus.btn_run = 1'b0;
        idle(40);
        check("after_reset_running", int'(bus.running), 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
